// File: rtl/pingpong_pkg.sv
// Shared types and width helpers for the ping-pong stream buffer.
package pingpong_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Lengths run 1..DEPTH, so one more code than the pointer range.
    function automatic int len_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pingpong_stream_buf_if.sv
// Producer-side and consumer-side valid/ready streams of the ping-pong buffer.
interface pingpong_stream_buf_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/pingpong_bank.sv
// One buffer bank: word storage, frame length and the EMPTY/FILLING/FULL/DRAINING lifecycle.
module pingpong_bank
    import pingpong_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int PTR_W = ptr_width(DEPTH),
    parameter int LEN_W = len_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             wr_close,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             rd_last,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [LEN_W-1:0] len,
    output logic             writable,
    output logic             readable
);
    bank_state_e      state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            len_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        mem_d   = mem_q;
        if (wr_en) mem_d[wr_addr] = wr_data;
        if (wr_en && wr_close) len_d = LEN_W'(wr_addr) + LEN_W'(1);
        case (state_q)
            EMPTY:    if (wr_en) state_d = wr_close ? FULL : FILLING;
            FILLING:  if (wr_en && wr_close) state_d = FULL;
            FULL:     if (rd_en) state_d = rd_last ? EMPTY : DRAINING;
            DRAINING: if (rd_en && rd_last) state_d = EMPTY;
            default:  state_d = EMPTY;
        endcase
    end

    always_comb begin
        writable = (state_q == EMPTY) || (state_q == FILLING);
        readable = (state_q == FULL)  || (state_q == DRAINING);
        rd_data  = mem_q[rd_addr];
        len      = len_q;
    end
endmodule

// File: rtl/pingpong_stream_buf.sv
// Two-bank ping-pong stream buffer: writer fills one bank while the reader drains the other,
// every output word carries a constant modular offset.
module pingpong_stream_buf
    import pingpong_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int OFFSET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    pingpong_stream_buf_if.slave  bus,
    output logic [1:0]            bank_full
);
    localparam int PTR_W = ptr_width(DEPTH);
    localparam int LEN_W = len_width(DEPTH);

    logic             wbank_q, wbank_d, rbank_q, rbank_d;
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;

    logic [1:0]       writable, readable, wr_en, rd_en;
    logic [WIDTH-1:0] rd_data [2];
    logic [LEN_W-1:0] len [2];
    logic             accept, close, fire, out_last;

    function automatic logic [WIDTH-1:0] add_offset(input logic [WIDTH-1:0] d);
        return d + WIDTH'(OFFSET);
    endfunction

    for (genvar b = 0; b < 2; b++) begin : g_bank
        pingpong_bank #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .PTR_W (PTR_W),
            .LEN_W (LEN_W)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en[b]),
            .wr_close (close),
            .wr_addr  (wptr_q),
            .wr_data  (bus.in_data),
            .rd_en    (rd_en[b]),
            .rd_last  (out_last),
            .rd_addr  (rptr_q),
            .rd_data  (rd_data[b]),
            .len      (len[b]),
            .writable (writable[b]),
            .readable (readable[b])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbank_q <= 1'b0;
            wptr_q  <= '0;
            rbank_q <= 1'b0;
            rptr_q  <= '0;
        end else begin
            wbank_q <= wbank_d;
            wptr_q  <= wptr_d;
            rbank_q <= rbank_d;
            rptr_q  <= rptr_d;
        end
    end

    always_comb begin
        bus.in_ready  = writable[wbank_q];
        accept        = bus.in_valid && bus.in_ready;
        close         = bus.in_last || (wptr_q == PTR_W'(DEPTH - 1));
        wr_en         = accept ? (wbank_q ? 2'b10 : 2'b01) : 2'b00;

        // out_data is purely combinational so a stalled consumer sees it unchanged.
        bus.out_valid = readable[rbank_q];
        out_last      = bus.out_valid && (LEN_W'(rptr_q) == len[rbank_q] - LEN_W'(1));
        bus.out_last  = out_last;
        bus.out_data  = add_offset(rd_data[rbank_q]);
        fire          = bus.out_valid && bus.out_ready;
        rd_en         = fire ? (rbank_q ? 2'b10 : 2'b01) : 2'b00;

        wbank_d = wbank_q;
        wptr_d  = wptr_q;
        if (accept) begin
            wptr_d = close ? '0 : wptr_q + PTR_W'(1);
            if (close) wbank_d = ~wbank_q;
        end

        rbank_d = rbank_q;
        rptr_d  = rptr_q;
        if (fire) begin
            rptr_d = out_last ? '0 : rptr_q + PTR_W'(1);
            if (out_last) rbank_d = ~rbank_q;
        end

        bank_full = readable;
    end
endmodule

// File: tb/tb_pingpong_stream_buf.sv
// Directed plus randomized bench for pingpong_stream_buf against a frame-queue reference model.
module tb_pingpong_stream_buf;
    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;
    localparam int OFFSET = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] bank_full;

    pingpong_stream_buf_if #(.WIDTH(WIDTH)) bus ();

    pingpong_stream_buf #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .OFFSET (OFFSET)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .bank_full (bank_full)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: closed frames waiting to be read, in arrival order.
    logic [7:0] q[$];
    int         lens[$];
    int         bankq[$];
    logic [7:0] pend[$];
    int         rd_idx;
    int         nclosed_total;

    bit         acc;
    int         cnt;
    logic [7:0] nextd;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        lens.delete();
        bankq.delete();
        pend.delete();
        rd_idx        = 0;
        nclosed_total = 0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_in_ready",  {7'd0, bus.in_ready},  8'd1);
        chk("rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
        chk("rst_out_last",  {7'd0, bus.out_last},  8'd0);
        chk("rst_bank_full", {6'd0, bank_full},     8'd0);
        chk("rst_out_data",  bus.out_data,          8'(OFFSET));
    endtask

    // One clock cycle: drive, check against model, clock, advance model.
    task automatic step(input bit v, input logic [7:0] d, input bit l, input bit ordy, output bit accepted);
        bit         mrdy, mov, mol;
        logic [7:0] mod;
        logic [1:0] mbf;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.out_ready = ordy;
        #2;
        mrdy = (lens.size() < 2);
        mov  = (lens.size() > 0);
        mol  = mov && (rd_idx == lens[0] - 1);
        mod  = mov ? q[rd_idx] + 8'(OFFSET) : 8'd0;
        mbf  = 2'b00;
        foreach (bankq[i]) mbf[bankq[i]] = 1'b1;
        chk("in_ready",  {7'd0, bus.in_ready},  {7'd0, mrdy});
        chk("out_valid", {7'd0, bus.out_valid}, {7'd0, mov});
        chk("out_last",  {7'd0, bus.out_last},  {7'd0, mol});
        chk("bank_full", {6'd0, bank_full},     {6'd0, mbf});
        if (mov) chk("out_data", bus.out_data, mod);
        accepted = v && mrdy;
        @(posedge clk);
        if (ordy && mov) begin
            if (mol) begin
                repeat (lens[0]) void'(q.pop_front());
                void'(lens.pop_front());
                void'(bankq.pop_front());
                rd_idx = 0;
            end else begin
                rd_idx++;
            end
        end
        if (accepted) begin
            pend.push_back(d);
            if (l || pend.size() == DEPTH) begin
                lens.push_back(pend.size());
                bankq.push_back(nclosed_total % 2);
                nclosed_total++;
                foreach (pend[i]) q.push_back(pend[i]);
                pend.delete();
            end
        end
        #1;
    endtask

    task automatic drain();
        bit a;
        for (int i = 0; i < 20 && lens.size() > 0; i++) step(1'b0, 8'd0, 1'b0, 1'b1, a);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        #12;
        check_reset_outputs();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // Two full frames streamed back to back.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(10 + i), 1'b0, 1'b1, acc);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(20 + i), 1'b0, 1'b1, acc);
        drain();

        // Partial frame closed by in_last.
        step(1'b1, 8'd5, 1'b0, 1'b1, acc);
        step(1'b1, 8'd6, 1'b1, 1'b1, acc);
        drain();
        step(1'b1, 8'd7, 1'b1, 1'b1, acc);
        drain();

        // Backpressure: consumer stalled while nine words are offered.
        nextd = 8'd60;
        cnt   = 0;
        for (int i = 0; i < 12; i++) begin
            step(cnt < 9, nextd, 1'b0, 1'b0, acc);
            if (acc) begin nextd++; cnt++; end
        end
        for (int i = 0; i < 20 && (cnt < 9 || lens.size() > 0); i++) begin
            step(cnt < 9, nextd, 1'b0, 1'b1, acc);
            if (acc) begin nextd++; cnt++; end
        end
        step(1'b1, 8'd99, 1'b1, 1'b1, acc);
        drain();

        // Wrap of the offset adder.
        step(1'b1, 8'hFF, 1'b1, 1'b1, acc);
        drain();

        // Stall mid-drain for three cycles.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(30 + i), 1'b0, 1'b1, acc);
        step(1'b0, 8'd0, 1'b0, 1'b1, acc);
        for (int i = 0; i < 3; i++) step(1'b0, 8'hA5, 1'b0, 1'b0, acc);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) != 0, acc);
        end
        drain();
        for (int i = 0; i < 8 && pend.size() > 0; i++) step(1'b1, 8'hEE, 1'b1, 1'b1, acc);
        drain();

        // Reset in the middle of traffic.
        for (int i = 0; i < 4; i++) step(1'b1, 8'(40 + i), 1'b0, 1'b0, acc);
        step(1'b1, 8'd50, 1'b0, 1'b1, acc);
        step(1'b1, 8'd51, 1'b0, 1'b0, acc);
        step(1'b1, 8'd52, 1'b0, 1'b0, acc);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) step(1'b1, 8'(1 + i), 1'b0, 1'b1, acc);
        drain();
        for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 1'b0, 1'b1, acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
